mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
// - Multicycle control unit for the 32-bit MIPS-subset CPU. Sequences a shared-ALU,
//   single-memory datapath through IF/ID/EXE/MEM/WB; replaces single-cycle combinational control.
// - Sits between the instruction register (op/func) plus ALU zero flag and all datapath
//   mux selects and write enables. Per-class cycle counts:
//   - j/jal/jr: 2
//   - beq/bne: 3
//   - R-type/ALU-imm/sw: 4
//   - lw: 5
// PARAMETERS
// - none (encodings fixed in mc_pkg)
// PORTS
// - clk      in   1  system clock, all state updates on rising edge
// - clrn     in   1  reset, asynchronous, active-low
// - op       in   6  inst[31:26] from instruction register
// - func     in   6  inst[5:0] from instruction register
// - z        in   1  ALU zero flag (valid in EXE)
// - wpc      out  1  PC write enable
// - wir      out  1  instruction register write enable
// - wmem     out  1  memory write enable
// - wreg     out  1  register file write enable
// - iord     out  1  memory address select: 0=PC, 1=ALU result register
// - alusrca  out  1  ALU A select: 0=PC, 1=rs register
// - alusrcb  out  2  ALU B select: 00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2
// - sext     out  1  immediate extension: 1=sign, 0=zero
// - shift    out  1  ALU A takes sa field (sll/srl/sra)
// - aluc     out  4  ALU operation code
// - pcsrc    out  2  next-PC select: 00=ALU, 01=branch-target reg, 10=rs, 11=jump addr
// - regrt    out  1  destination select: 1=rt, 0=rd
// - m2reg    out  1  writeback data select: 1=memory data, 0=ALU result register
// - jal      out  1  writeback forces reg31 <- PC (already PC+4)
// - illegal  out  1  1-cycle pulse in ID on undecodable op/func
// - state    out  3  current state (debug)
// BEHAVIOUR
// - Reset: state=S_IF asynchronously; wpc/wir/wmem/wreg/illegal forced 0 while clrn=0.
//   Selects follow S_IF decode. First IF write occurs on the first rising edge with clrn=1.
// - Outputs are combinational from state, op, func, z. State is the only register.
// - Default value of every output is 0 unless asserted below.
// - S_IF: iord=0, alusrcb=01, aluc=ADD, pcsrc=00, wpc=1, wir=1 -> S_ID.
// - S_ID: alusrcb=11, sext=1, aluc=ADD (branch target latched externally).
//   - j: wpc=1, pcsrc=11 -> S_IF
//   - jal: as j, plus wreg=1, jal=1 -> S_IF
//   - jr: wpc=1, pcsrc=10 -> S_IF
//   - illegal: illegal=1, no writes -> S_IF
//   - otherwise -> S_EXE
// - S_EXE: alusrca=1.
//   - R-type: alusrcb=00; aluc from func; shift=1 for sll/srl/sra -> S_WB
//   - addi/lw/sw: alusrcb=10, sext=1, aluc=ADD; lw/sw -> S_MEM, addi -> S_WB
//   - andi/ori/xori/lui: alusrcb=10, sext=0, aluc=AND/OR/XOR/LUI -> S_WB
//   - beq/bne: alusrcb=00, aluc=SUB; wpc=1, pcsrc=01 iff (beq&z)|(bne&~z) -> S_IF
// - S_MEM: iord=1.
//   - sw: wmem=1 -> S_IF
//   - lw -> S_WB
// - S_WB: wreg=1; regrt=1 for I-type; m2reg=1 for lw -> S_IF.
// - Simultaneous events:
//   - z is sampled only in S_EXE; ignored elsewhere.
//   - op/func change outside S_ID/S_EXE/S_MEM/S_WB is don't-care (IR holds).
// - Reset mid-instruction: abandon at once; state->S_IF; no partial write pulse after clrn falls.
// - Unused state encodings recover to S_IF on the next edge with all write enables 0.
// - Supported set:
//   - R-type: add sub and or xor sll srl sra jr
//   - I-type: addi andi ori xori lw sw beq bne lui
//   - J-type: j jal
//   - anything else is illegal
// STRUCTURE
// - mc_pkg:
//   - state_t enum: S_IF=0, S_ID=1, S_EXE=2, S_MEM=3, S_WB=4
//   - OP_* and FN_* localparams
//   - ALUC_* codes: ADD=x000, SUB=x100, AND=x001, OR=x101, XOR=x010, LUI=x110,
//     SLL=0011, SRL=0111, SRA=1111
//   - PCSRC_* and ALUB_* select codes
// - Sub-module mc_decode (combinational): op, func -> one-hot class flags
//   (rtype, shift, jr, j, jal, ialu, lw, sw, beq, bne, lui, illegal) and the R-type aluc.
//   The FSM consumes only these flags.
// TESTING
// - Reset: clrn=0 for 6 ns, clk period 10 ns -> state=S_IF, wpc=wir=wmem=wreg=0 throughout;
//   first wpc&wir pulse on the first edge after release.
// - add $3,$1,$2 (op=0, func=0x20) -> states IF,ID,EXE,WB.
//   - EXE: aluc=ADD, alusrcb=00
//   - WB: wreg=1, regrt=0, m2reg=0
// - lw (op=0x23) -> 5 states; MEM iord=1; WB wreg=1, m2reg=1, regrt=1.
//   sw (op=0x2B) -> 4 states; wmem=1 only in MEM.
// - beq with z=1 -> wpc=1, pcsrc=01 in EXE.
//   beq with z=0 -> wpc=0.
//   bne inverts both cases.
//   Either way the next state is S_IF after 3 cycles.
// - j/jal/jr -> 2 cycles:
//   - j and jal: pcsrc=11
//   - jal: additionally wreg=1, jal=1
//   - jr: pcsrc=10
// - op=0x3F -> illegal=1 for one cycle in ID, no write enables, back to S_IF.
//   clrn pulsed low in S_MEM of sw -> wmem never asserts; state=S_IF.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: states,
// opcode/function fields, ALU operation codes and datapath select codes.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_RS     = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    localparam logic [1:0] ALUB_RT   = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;
    localparam logic [1:0] ALUB_BOFS = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// Instruction classifier: maps op/func to one-hot class flags and the ALU
// operation for register and immediate ALU instructions.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output logic       rtype,
    output logic       shift,
    output logic       jr,
    output logic       j,
    output logic       jal,
    output logic       ialu,
    output logic       lw,
    output logic       sw,
    output logic       beq,
    output logic       bne,
    output logic       lui,
    output logic       illegal,
    output logic [3:0] aluc
);

    always_comb begin
        rtype   = 1'b0;
        shift   = 1'b0;
        jr      = 1'b0;
        j       = 1'b0;
        jal     = 1'b0;
        ialu    = 1'b0;
        lw      = 1'b0;
        sw      = 1'b0;
        beq     = 1'b0;
        bne     = 1'b0;
        lui     = 1'b0;
        illegal = 1'b0;
        aluc    = ALUC_ADD;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD: begin rtype = 1'b1; aluc = ALUC_ADD; end
                    FN_SUB: begin rtype = 1'b1; aluc = ALUC_SUB; end
                    FN_AND: begin rtype = 1'b1; aluc = ALUC_AND; end
                    FN_OR:  begin rtype = 1'b1; aluc = ALUC_OR;  end
                    FN_XOR: begin rtype = 1'b1; aluc = ALUC_XOR; end
                    FN_SLL: begin rtype = 1'b1; shift = 1'b1; aluc = ALUC_SLL; end
                    FN_SRL: begin rtype = 1'b1; shift = 1'b1; aluc = ALUC_SRL; end
                    FN_SRA: begin rtype = 1'b1; shift = 1'b1; aluc = ALUC_SRA; end
                    FN_JR:  jr = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin ialu = 1'b1; aluc = ALUC_ADD; end
            OP_ANDI: begin ialu = 1'b1; aluc = ALUC_AND; end
            OP_ORI:  begin ialu = 1'b1; aluc = ALUC_OR;  end
            OP_XORI: begin ialu = 1'b1; aluc = ALUC_XOR; end
            OP_LUI:  begin lui  = 1'b1; aluc = ALUC_LUI; end
            OP_LW:   lw  = 1'b1;
            OP_SW:   sw  = 1'b1;
            OP_BEQ:  beq = 1'b1;
            OP_BNE:  bne = 1'b1;
            OP_J:    j   = 1'b1;
            OP_JAL:  jal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: steps a shared-ALU, single-memory datapath through
// IF/ID/EXE/MEM/WB and drives every select and write enable combinationally.
module mc_control_fsm
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       clrn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       sext,
    output logic       shift,
    output logic [3:0] aluc,
    output logic [1:0] pcsrc,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       illegal,
    output logic [2:0] state
);

    logic       dec_rtype, dec_shift, dec_jr, dec_j, dec_jal, dec_ialu;
    logic       dec_lw, dec_sw, dec_beq, dec_bne, dec_lui, dec_illegal;
    logic [3:0] dec_aluc;
    logic [2:0] next_state;
    logic       wpc_d, wir_d, wmem_d, wreg_d, illegal_d;

    mc_decode u_decode (
        .op      (op),
        .func    (func),
        .rtype   (dec_rtype),
        .shift   (dec_shift),
        .jr      (dec_jr),
        .j       (dec_j),
        .jal     (dec_jal),
        .ialu    (dec_ialu),
        .lw      (dec_lw),
        .sw      (dec_sw),
        .beq     (dec_beq),
        .bne     (dec_bne),
        .lui     (dec_lui),
        .illegal (dec_illegal),
        .aluc    (dec_aluc)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= S_IF;
        else       state <= next_state;
    end

    always_comb begin
        next_state = S_IF;
        wpc_d      = 1'b0;
        wir_d      = 1'b0;
        wmem_d     = 1'b0;
        wreg_d     = 1'b0;
        illegal_d  = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = ALUB_RT;
        sext       = 1'b0;
        shift      = 1'b0;
        aluc       = ALUC_ADD;
        pcsrc      = PCSRC_ALU;
        regrt      = 1'b0;
        m2reg      = 1'b0;
        jal        = 1'b0;
        case (state)
            S_IF: begin
                alusrcb    = ALUB_FOUR;
                wpc_d      = 1'b1;
                wir_d      = 1'b1;
                next_state = S_ID;
            end
            S_ID: begin
                // ALU computes the branch target here while it is otherwise idle
                alusrcb = ALUB_BOFS;
                sext    = 1'b1;
                if (dec_j || dec_jal) begin
                    wpc_d = 1'b1;
                    pcsrc = PCSRC_JUMP;
                    if (dec_jal) begin
                        wreg_d = 1'b1;
                        jal    = 1'b1;
                    end
                end else if (dec_jr) begin
                    wpc_d = 1'b1;
                    pcsrc = PCSRC_RS;
                end else if (dec_illegal) begin
                    illegal_d = 1'b1;
                end else begin
                    next_state = S_EXE;
                end
            end
            S_EXE: begin
                alusrca = 1'b1;
                if (dec_rtype) begin
                    aluc       = dec_aluc;
                    shift      = dec_shift;
                    next_state = S_WB;
                end else if (dec_ialu || dec_lui || dec_lw || dec_sw) begin
                    // only addi and memory offsets are sign-extended; logical ops zero-extend
                    alusrcb    = ALUB_IMM;
                    sext       = dec_lw || dec_sw || (dec_ialu && dec_aluc == ALUC_ADD);
                    aluc       = dec_aluc;
                    next_state = (dec_lw || dec_sw) ? S_MEM : S_WB;
                end else if (dec_beq || dec_bne) begin
                    aluc = ALUC_SUB;
                    if ((dec_beq && z) || (dec_bne && !z)) begin
                        wpc_d = 1'b1;
                        pcsrc = PCSRC_BRANCH;
                    end
                end
            end
            S_MEM: begin
                iord = 1'b1;
                if (dec_sw)      wmem_d     = 1'b1;
                else if (dec_lw) next_state = S_WB;
            end
            S_WB: begin
                wreg_d = 1'b1;
                regrt  = dec_ialu || dec_lui || dec_lw;
                m2reg  = dec_lw;
            end
            default: next_state = S_IF;
        endcase
    end

    // Write enables are held off for the whole time clrn is low
    assign wpc     = wpc_d & clrn;
    assign wir     = wir_d & clrn;
    assign wmem    = wmem_d & clrn;
    assign wreg    = wreg_d & clrn;
    assign illegal = illegal_d & clrn;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: reset behaviour, a table of per-instruction
// outcomes, a mid-instruction reset, and randomized instructions vs. a model.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       clrn;
    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    logic       wpc, wir, wmem, wreg, iord, alusrca, sext, shift;
    logic       regrt, m2reg, jal, illegal;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] aluc;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       wpc, wir, wmem, wreg, iord, alusrca;
        logic [1:0] alusrcb;
        logic       sext, shift;
        logic [3:0] aluc;
        logic [1:0] pcsrc;
        logic       regrt, m2reg, jal, illegal;
        logic [2:0] state;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        logic       z;
        int         ncyc;
        out_t       last;
    } vec_t;

    typedef enum int {K_R, K_SH, K_JR, K_J, K_JAL, K_IMM, K_LUI, K_LW, K_SW,
                      K_BEQ, K_BNE, K_ILL} kind_t;

    mc_control_fsm dut (
        .clk     (clk),
        .clrn    (clrn),
        .op      (op),
        .func    (func),
        .z       (z),
        .wpc     (wpc),
        .wir     (wir),
        .wmem    (wmem),
        .wreg    (wreg),
        .iord    (iord),
        .alusrca (alusrca),
        .alusrcb (alusrcb),
        .sext    (sext),
        .shift   (shift),
        .aluc    (aluc),
        .pcsrc   (pcsrc),
        .regrt   (regrt),
        .m2reg   (m2reg),
        .jal     (jal),
        .illegal (illegal),
        .state   (state)
    );

    always #5 clk = ~clk;

    function automatic out_t get_out();
        return '{wpc, wir, wmem, wreg, iord, alusrca, alusrcb, sext, shift,
                 aluc, pcsrc, regrt, m2reg, jal, illegal, state};
    endfunction

    function automatic out_t mk(logic wp, logic wi, logic wm, logic wr, logic io,
                                logic asa, logic [1:0] asb, logic sx, logic sh,
                                logic [3:0] ac, logic [1:0] ps, logic rt,
                                logic mr, logic jl, logic il, logic [2:0] st);
        return '{wp, wi, wm, wr, io, asa, asb, sx, sh, ac, ps, rt, mr, jl, il, st};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: instruction set table -> class and ALU code
    function automatic kind_t classify(logic [5:0] o, logic [5:0] f, output logic [3:0] alu);
        alu = 4'b0000;
        if (o == 6'h00) begin
            case (f)
                6'h20: return K_R;
                6'h22: begin alu = 4'b0100; return K_R; end
                6'h24: begin alu = 4'b0001; return K_R; end
                6'h25: begin alu = 4'b0101; return K_R; end
                6'h26: begin alu = 4'b0010; return K_R; end
                6'h00: begin alu = 4'b0011; return K_SH; end
                6'h02: begin alu = 4'b0111; return K_SH; end
                6'h03: begin alu = 4'b1111; return K_SH; end
                6'h08: return K_JR;
                default: return K_ILL;
            endcase
        end
        case (o)
            6'h08: return K_IMM;
            6'h0C: begin alu = 4'b0001; return K_IMM; end
            6'h0D: begin alu = 4'b0101; return K_IMM; end
            6'h0E: begin alu = 4'b0010; return K_IMM; end
            6'h0F: begin alu = 4'b0110; return K_LUI; end
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic int ncycles(kind_t k);
        case (k)
            K_J, K_JAL, K_JR, K_ILL: return 2;
            K_BEQ, K_BNE:            return 3;
            K_LW:                    return 5;
            default:                 return 4;
        endcase
    endfunction

    // Expected outputs in cycle k (0 = fetch) of an instruction
    function automatic out_t model(logic [5:0] o, logic [5:0] f, logic zz, int k);
        out_t r;
        logic [3:0] alu;
        kind_t kd;
        int ph;
        kd = classify(o, f, alu);
        r  = '0;
        ph = (k == 3 && kd != K_LW && kd != K_SW) ? 4 : k;
        r.state = ph[2:0];
        case (ph)
            0: begin r.alusrcb = 2'b01; r.wpc = 1'b1; r.wir = 1'b1; end
            1: begin
                r.alusrcb = 2'b11; r.sext = 1'b1;
                if (kd == K_J || kd == K_JAL) begin r.wpc = 1'b1; r.pcsrc = 2'b11; end
                if (kd == K_JAL) begin r.wreg = 1'b1; r.jal = 1'b1; end
                if (kd == K_JR) begin r.wpc = 1'b1; r.pcsrc = 2'b10; end
                if (kd == K_ILL) r.illegal = 1'b1;
            end
            2: begin
                r.alusrca = 1'b1;
                if (kd == K_R || kd == K_SH) begin
                    r.aluc = alu; r.shift = (kd == K_SH);
                end else if (kd == K_BEQ || kd == K_BNE) begin
                    r.aluc = 4'b0100;
                    if ((kd == K_BEQ) == zz) begin r.wpc = 1'b1; r.pcsrc = 2'b01; end
                end else begin
                    r.alusrcb = 2'b10;
                    r.aluc    = alu;
                    r.sext    = (kd == K_LW || kd == K_SW || (kd == K_IMM && alu == 4'b0000));
                end
            end
            3: begin r.iord = 1'b1; r.wmem = (kd == K_SW); end
            default: begin
                r.wreg  = 1'b1;
                r.regrt = (kd == K_IMM || kd == K_LUI || kd == K_LW);
                r.m2reg = (kd == K_LW);
            end
        endcase
        return r;
    endfunction

    // Run one instruction from IF; report cycle count and last-cycle outputs
    task automatic run_vec(input int idx, input vec_t v);
        out_t prev;
        int n;
        op = v.op; func = v.func; z = v.z;
        #1;
        n = 0;
        prev = '0;
        do begin
            prev = get_out();
            n++;
            @(negedge clk); #1;
        end while (state != 3'd0 && n < 8);
        check($sformatf("vec%0d_cycles", idx), n, v.ncyc);
        check($sformatf("vec%0d_last", idx), 32'(prev), 32'(v.last));
    endtask

    task automatic run_model(input int idx, input logic [5:0] o, input logic [5:0] f);
        logic [3:0] alu;
        int nc;
        nc = ncycles(classify(o, f, alu));
        op = o; func = f;
        for (int k = 0; k < nc; k++) begin
            z = 1'($urandom);
            #1;
            check($sformatf("rand%0d_k%0d", idx, k), 32'(get_out()), 32'(model(o, f, z, k)));
            @(negedge clk);
        end
    endtask

    vec_t tbl[15];
    logic [11:0] legal[18];

    initial begin
        tbl[0]  = '{6'h00, 6'h20, 1'b0, 4, mk(0,0,0,1,0,0,2'b00,0,0,4'h0,2'b00,0,0,0,0,3'd4)};
        tbl[1]  = '{6'h00, 6'h00, 1'b1, 4, mk(0,0,0,1,0,0,2'b00,0,0,4'h0,2'b00,0,0,0,0,3'd4)};
        tbl[2]  = '{6'h08, 6'h00, 1'b0, 4, mk(0,0,0,1,0,0,2'b00,0,0,4'h0,2'b00,1,0,0,0,3'd4)};
        tbl[3]  = '{6'h0F, 6'h00, 1'b0, 4, mk(0,0,0,1,0,0,2'b00,0,0,4'h0,2'b00,1,0,0,0,3'd4)};
        tbl[4]  = '{6'h23, 6'h00, 1'b0, 5, mk(0,0,0,1,0,0,2'b00,0,0,4'h0,2'b00,1,1,0,0,3'd4)};
        tbl[5]  = '{6'h2B, 6'h00, 1'b0, 4, mk(0,0,1,0,1,0,2'b00,0,0,4'h0,2'b00,0,0,0,0,3'd3)};
        tbl[6]  = '{6'h04, 6'h00, 1'b1, 3, mk(1,0,0,0,0,1,2'b00,0,0,4'h4,2'b01,0,0,0,0,3'd2)};
        tbl[7]  = '{6'h04, 6'h00, 1'b0, 3, mk(0,0,0,0,0,1,2'b00,0,0,4'h4,2'b00,0,0,0,0,3'd2)};
        tbl[8]  = '{6'h05, 6'h00, 1'b0, 3, mk(1,0,0,0,0,1,2'b00,0,0,4'h4,2'b01,0,0,0,0,3'd2)};
        tbl[9]  = '{6'h05, 6'h00, 1'b1, 3, mk(0,0,0,0,0,1,2'b00,0,0,4'h4,2'b00,0,0,0,0,3'd2)};
        tbl[10] = '{6'h02, 6'h00, 1'b0, 2, mk(1,0,0,0,0,0,2'b11,1,0,4'h0,2'b11,0,0,0,0,3'd1)};
        tbl[11] = '{6'h03, 6'h00, 1'b0, 2, mk(1,0,0,1,0,0,2'b11,1,0,4'h0,2'b11,0,0,1,0,3'd1)};
        tbl[12] = '{6'h00, 6'h08, 1'b0, 2, mk(1,0,0,0,0,0,2'b11,1,0,4'h0,2'b10,0,0,0,0,3'd1)};
        tbl[13] = '{6'h3F, 6'h00, 1'b0, 2, mk(0,0,0,0,0,0,2'b11,1,0,4'h0,2'b00,0,0,0,1,3'd1)};
        tbl[14] = '{6'h00, 6'h21, 1'b0, 2, mk(0,0,0,0,0,0,2'b11,1,0,4'h0,2'b00,0,0,0,1,3'd1)};

        legal = '{12'h020, 12'h022, 12'h024, 12'h025, 12'h026, 12'h000, 12'h002,
                  12'h003, 12'h008, 12'h200, 12'h300, 12'h340, 12'h380, 12'h3C0,
                  12'h8C0, 12'hAC0, 12'h100, 12'h140};

        // Reset asserted from time 0 for 6 ns, spanning the first rising edge
        clrn = 1'b0; op = 6'h00; func = 6'h20; z = 1'b0;
        #2;
        check("rst_state_t2", 32'(state), 32'd0);
        check("rst_we_t2", {28'd0, wpc, wir, wmem, wreg}, 32'd0);
        #4;
        check("rst_state_t6", 32'(state), 32'd0);
        check("rst_we_t6", {28'd0, wpc, wir, wmem, wreg}, 32'd0);
        clrn = 1'b1;
        @(negedge clk); #1;
        check("first_if_we", {30'd0, wpc, wir}, 32'd3);
        check("first_if_state", 32'(state), 32'd0);

        for (int i = 0; i < 15; i++) run_vec(i, tbl[i]);

        // Reset pulsed while sw sits in MEM: the store must never be issued
        op = 6'h2B; func = 6'h00; z = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("sw_reached_mem", 32'(state), 32'd3);
        clrn = 1'b0;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_wmem", 32'(wmem), 32'd0);
        @(posedge clk); #1;
        check("midrst_hold_we", {28'd0, wpc, wir, wmem, wreg}, 32'd0);
        @(negedge clk);
        clrn = 1'b1;
        #1;
        check("midrst_release_state", 32'(state), 32'd0);
        check("midrst_release_we", {28'd0, wpc, wir, wmem, wreg}, 32'hC);
        #1;
        @(negedge clk);
        // One IF cycle consumed above; the second negedge lands back in IF only if
        // a full instruction ran, so restart cleanly with a jump to re-align.
        check("realign_state", 32'(state), 32'd1);
        op = 6'h02;
        @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            logic [5:0] o, f;
            if ($urandom_range(0, 9) < 8) begin
                int s;
                s = $urandom_range(0, 17);
                o = legal[s][11:6];
                f = (o == 6'h00) ? legal[s][5:0] : 6'($urandom);
            end else begin
                o = 6'($urandom);
                f = 6'($urandom);
            end
            run_model(i, o, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
